// File: rtl/clken_gen.sv
// Fractional clock-enable generator: per-channel phase accumulators emit ce pulses at
// exactly inc/mod of refclk, gated by a synchronised PLL lock qualifier with settle time.
module clken_gen #(
  parameter int NUM_CH     = 3,
  parameter int ACC_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {ACC_W'(1), ACC_W'(1), ACC_W'(1)},
  parameter logic [NUM_CH*ACC_W-1:0] MOD_INIT = {ACC_W'(1), ACC_W'(2), ACC_W'(8)}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_mod,
  output logic [NUM_CH-1:0] ce,
  output logic              ready,
  output logic [7:0]        unlock_cnt
);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t            state, state_nxt;
  logic              lk_meta, lk;
  logic [15:0]       settle_cnt;
  logic              run_step, lock_lost, ready_nxt;
  logic [ACC_W-1:0]  inc [NUM_CH];
  logic [ACC_W-1:0]  mod [NUM_CH];
  logic [ACC_W:0]    acc [NUM_CH];
  logic              step_hit [NUM_CH];
  logic [ACC_W:0]    step_acc [NUM_CH];

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Returns {pulse, next_acc}. When inc >= mod the rate is already one pulse per
  // cycle, so the accumulator is pinned at 0 to keep acc < mod and avoid wrap-around.
  function automatic logic [ACC_W+1:0] acc_step(input logic [ACC_W:0]   a,
                                                input logic [ACC_W-1:0] i,
                                                input logic [ACC_W-1:0] m);
    logic [ACC_W:0] s;
    s = a + {1'b0, i};
    if (i >= m)
      return {1'b1, {(ACC_W+1){1'b0}}};
    else if (s >= {1'b0, m})
      return {1'b1, s - {1'b0, m}};
    else
      return {1'b0, s};
  endfunction

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
      state   <= WAIT_LOCK;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
      state   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (lk) state_nxt = SETTLE;
      SETTLE: begin
        if (!lk)                           state_nxt = WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      RUN:       if (!lk) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    run_step  = (state == RUN) && lk;
    lock_lost = (state == RUN) && !lk;
    ready_nxt = (state_nxt == RUN);
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      {step_hit[n], step_acc[n]} = acc_step(acc[n], inc[n], mod[n]);
    end
  end

  // Control and status registers
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      ready      <= 1'b0;
      unlock_cnt <= '0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + 16'd1 : 16'd0;
      ready      <= ready_nxt;
      if (lock_lost) unlock_cnt <= sat_inc8(unlock_cnt);
    end
  end

  // Per-channel configuration and phase accumulators
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        inc[n] <= INC_INIT[n*ACC_W +: ACC_W];
        mod[n] <= MOD_INIT[n*ACC_W +: ACC_W];
        acc[n] <= '0;
        ce[n]  <= 1'b0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (cfg_we && (int'(cfg_ch) == n)) begin
          inc[n] <= cfg_inc;
          mod[n] <= cfg_mod;
          acc[n] <= '0;
          ce[n]  <= 1'b0;
        end else if (run_step && (inc[n] != '0) && (mod[n] != '0)) begin
          acc[n] <= step_acc[n];
          ce[n]  <= step_hit[n];
        end else begin
          acc[n] <= '0;
          ce[n]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Randomised self-checking bench for clken_gen: a reference model derives ce from
// floor(k*inc/mod) steps and ready from the length of the synchronised lock streak.
module tb_clken_gen;
  localparam int NUM_CH     = 3;
  localparam int ACC_W      = 16;
  localparam int SETTLE_CYC = 16;

  logic              refclk = 1'b0;
  logic              rst, pll_locked, cfg_we;
  logic [2:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc, cfg_mod;
  logic [NUM_CH-1:0] ce;
  logic              ready;
  logic [7:0]        unlock_cnt;

  clken_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_mod(cfg_mod),
    .ce(ce), .ready(ready), .unlock_cnt(unlock_cnt)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  longint m_inc [NUM_CH];
  longint m_mod [NUM_CH];
  longint m_steps [NUM_CH];
  bit     m_ce [NUM_CH];
  int     streak;
  bit     m_ready;
  int     m_unlock;
  bit     lkq [$];

  task automatic model_reset();
    m_inc = '{1, 1, 1};
    m_mod = '{8, 2, 1};
    for (int n = 0; n < NUM_CH; n++) begin
      m_steps[n] = 0;
      m_ce[n]    = 1'b0;
    end
    streak   = 0;
    m_ready  = 1'b0;
    m_unlock = 0;
    lkq.delete();
    lkq.push_back(1'b0);
    lkq.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit lkv, was_run;
    lkq.push_back(pll_locked);
    lkv     = lkq.pop_front();
    was_run = m_ready;
    streak  = lkv ? streak + 1 : 0;
    m_ready = (streak >= SETTLE_CYC + 1);
    if (was_run && !lkv && m_unlock < 255) m_unlock++;
    for (int n = 0; n < NUM_CH; n++) begin
      if (cfg_we && int'(cfg_ch) == n) begin
        m_inc[n]   = cfg_inc;
        m_mod[n]   = cfg_mod;
        m_steps[n] = 0;
        m_ce[n]    = 1'b0;
      end else if (was_run && lkv && m_inc[n] != 0 && m_mod[n] != 0) begin
        m_steps[n]++;
        m_ce[n] = ((m_steps[n] * m_inc[n]) / m_mod[n]) != (((m_steps[n] - 1) * m_inc[n]) / m_mod[n]);
      end else begin
        m_steps[n] = 0;
        m_ce[n]    = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [NUM_CH-1:0] exp_ce;
    @(posedge refclk);
    model_edge();
    #1;
    for (int n = 0; n < NUM_CH; n++) exp_ce[n] = m_ce[n];
    check("ce", ce, exp_ce);
    check("ready", ready, m_ready);
    check("unlock_cnt", unlock_cnt, m_unlock);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int i, input int m);
    cfg_we  = 1'b1;
    cfg_ch  = 3'(ch);
    cfg_inc = ACC_W'(i);
    cfg_mod = ACC_W'(m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_ready, pulses, cnt_before, drop_left;
    bit saw_ready, ce1_seen;

    rst = 1'b1; pll_locked = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_inc = '0; cfg_mod = '0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    check("reset_ce", ce, 0);
    check("reset_ready", ready, 0);
    check("reset_unlock", unlock_cnt, 0);

    // Power-up with lock held high
    rst = 1'b0;
    pll_locked = 1'b1;
    t_ready = 0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (ready && t_ready == 0) t_ready = i;
    end
    check("ready_latency_in_17_19", (t_ready >= 17 && t_ready <= 19), 1);

    // 2/5 rate on channel 0
    cfg_write(0, 2, 5);
    cycle();
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      pulses += int'(ce[0]);
    end
    check("ch0_2of5_pulses", pulses, 400);

    // Short lock loss during RUN
    pll_locked = 1'b0;
    repeat (3) cycle();
    pll_locked = 1'b1;
    repeat (40) cycle();
    check("unlock_after_drop", unlock_cnt, 1);
    check("ready_after_relock", ready, 1);

    // Lock lost during SETTLE
    pll_locked = 1'b0;
    repeat (5) cycle();
    cnt_before = unlock_cnt;
    pll_locked = 1'b1;
    saw_ready = 1'b0;
    repeat (12) begin cycle(); saw_ready |= ready; end
    pll_locked = 1'b0;
    repeat (30) begin cycle(); saw_ready |= ready; end
    check("settle_abort_no_ready", saw_ready, 0);
    check("settle_abort_unlock", unlock_cnt, cnt_before);

    // Out-of-range channel write, then disable channel 1
    pll_locked = 1'b1;
    repeat (25) cycle();
    cfg_write(7, 3, 4);
    cycle();
    cfg_write(1, 5, 0);
    cycle();
    ce1_seen = 1'b0;
    repeat (50) begin cycle(); ce1_seen |= ce[1]; end
    check("ch1_disabled", ce1_seen, 0);

    // Random configuration writes and lock drops
    drop_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop_left == 0 && $urandom_range(199) == 0) drop_left = $urandom_range(4, 1);
      pll_locked = (drop_left == 0);
      if (drop_left > 0) drop_left--;
      if ($urandom_range(49) == 0)
        cfg_write($urandom_range(7), $urandom_range(12), $urandom_range(12));
      cycle();
    end

    // Saturate the unlock counter
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b1;
      repeat (22) cycle();
      pll_locked = 1'b0;
      repeat (3) cycle();
    end
    check("unlock_saturated", unlock_cnt, 255);

    // Asynchronous reset mid-run with a pending write
    pll_locked = 1'b1;
    cfg_write(0, 3, 7);
    cycle();
    repeat (25) cycle();
    cfg_write(2, 9, 11);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ce", ce, 0);
    check("async_rst_ready", ready, 0);
    check("async_rst_unlock", unlock_cnt, 0);
    cfg_we = 1'b0;
    model_reset();
    @(posedge refclk);
    #1;
    rst = 1'b0;
    repeat (60) cycle();
    check("ready_after_rst", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
